// File: rtl/sr_hyp_unit_pkg.sv
// Shared definitions for the sr_hyp_unit coprocessor: operation codes and
// controller state encoding.
package sr_hyp_unit_pkg;

  // Operation selected by op_i at start.
  typedef enum logic [1:0] {
    OP_HYP   = 2'd0,  // floor(sqrt(a*a + b*b))
    OP_MUL   = 2'd1,  // a*b
    OP_SQRT  = 2'd2,  // floor(sqrt(a))
    OP_SQSUM = 2'd3   // a*a + b*b
  } op_t;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL_A = 3'd1,
    ST_MUL_B = 3'd2,
    ST_SQRT  = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/sr_isqrt_serial.sv
// Bit-serial restoring square root. One root bit per step, MSB first.
// RW must be even; the root is RW/2 bits and is complete after RW/2 steps.
module sr_isqrt_serial #(
  parameter int RW = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [RW-1:0]   radicand,
  input  logic            step,
  output logic [RW/2-1:0] root,
  output logic [RW/2+1:0] remainder
);
  localparam int HW = RW / 2;

  logic [RW-1:0] r_rad;
  logic [HW-1:0] r_root;
  logic [HW+1:0] r_rem;

  logic [HW+1:0] w_rem_sh;
  logic [HW+1:0] w_trial;
  logic          w_fit;

  // Bring down the next two radicand bits and try root*4+1 against them.
  // The remainder never exceeds 2*root, so its top two bits are always zero
  // before the shift and HW+2 bits are enough to hold the shifted value.
  assign w_rem_sh = {r_rem[HW-1:0], r_rad[RW-1:RW-2]};
  assign w_trial  = {r_root, 2'b01};
  assign w_fit    = (w_rem_sh >= w_trial);

  // Load a fresh radicand, or resolve one root bit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad  <= '0;
      r_root <= '0;
      r_rem  <= '0;
    end else if (load) begin
      r_rad  <= radicand;
      r_root <= '0;
      r_rem  <= '0;
    end else if (step) begin
      r_rad  <= {r_rad[RW-3:0], 2'b00};
      r_root <= {r_root[HW-2:0], w_fit};
      r_rem  <= w_fit ? (w_rem_sh - w_trial) : w_rem_sh;
    end
  end

  assign root      = r_root;
  assign remainder = r_rem;

endmodule

// File: rtl/sr_hyp_unit.sv
// Multi-cycle arithmetic coprocessor: hypotenuse, product, square root and
// sum of squares, built from a shift-add multiplier and a serial square root.
module sr_hyp_unit
  import sr_hyp_unit_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     a_bi,
  input  logic [WIDTH-1:0]     b_bi,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [OUT_WIDTH-1:0] y_bo
);
  // Accumulator / radicand width and shared iteration counter width.
  localparam int AW = 2 * WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 2);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("sr_hyp_unit: WIDTH must be at least 2");
    end
    if (OUT_WIDTH < 2 * WIDTH + 1) begin : g_bad_out_width
      $error("sr_hyp_unit: OUT_WIDTH must be at least 2*WIDTH+1");
    end
  endgenerate

  state_t               r_state;
  op_t                  r_op;
  logic [CW-1:0]        r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [OUT_WIDTH-1:0] r_y;

  logic [AW-1:0]        r_acc;
  logic [AW-1:0]        r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_b;

  logic                 w_start;
  logic                 w_mul_active;
  logic                 w_mul_last;
  logic                 w_sqrt_last;
  logic [AW-1:0]        w_acc_next;
  logic                 w_sq_load;
  logic                 w_sq_step;
  logic [AW-1:0]        w_sq_rad;
  logic [WIDTH:0]       w_root;
  logic [WIDTH+2:0]     w_sqrt_rem_unused;

  assign w_start      = (r_state == ST_IDLE) && start_i && !abort_i;
  assign w_mul_active = (r_state == ST_MUL_A) || (r_state == ST_MUL_B);
  assign w_mul_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_sqrt_last  = (r_cnt == CW'(WIDTH));
  assign w_acc_next   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // The root unit is loaded either straight from a (SQRT) or with the final
  // sum of squares on the same edge the last MUL_B partial product lands.
  assign w_sq_load = (w_start && (op_i == OP_SQRT)) ||
                     ((r_state == ST_MUL_B) && w_mul_last && (r_op == OP_HYP) && !abort_i);
  assign w_sq_step = (r_state == ST_SQRT) && !abort_i;
  assign w_sq_rad  = (r_state == ST_IDLE) ? AW'(a_bi) : w_acc_next;

  sr_isqrt_serial #(
    .RW(AW)
  ) u_isqrt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_sq_load),
    .radicand  (w_sq_rad),
    .step      (w_sq_step),
    .root      (w_root),
    .remainder (w_sqrt_rem_unused)
  );

  // Controller: sequencing, iteration counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_HYP;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != ST_IDLE) && abort_i) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_op    <= op_t'(op_i);
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_state <= (op_i == OP_SQRT) ? ST_SQRT : ST_MUL_A;
            end
          end
          ST_MUL_A: begin
            if (w_mul_last) begin
              r_cnt   <= '0;
              r_state <= (r_op == OP_MUL) ? ST_FIN : ST_MUL_B;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          ST_MUL_B: begin
            if (w_mul_last) begin
              r_cnt   <= '0;
              r_state <= (r_op == OP_HYP) ? ST_SQRT : ST_FIN;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          ST_SQRT: begin
            if (w_sqrt_last) begin
              r_cnt   <= '0;
              r_state <= ST_FIN;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          ST_FIN: begin
            r_y     <= ((r_op == OP_HYP) || (r_op == OP_SQRT)) ? OUT_WIDTH'(w_root)
                                                               : OUT_WIDTH'(r_acc);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Shift-add multiplier: one multiplier bit per MUL_A/MUL_B cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_b      <= '0;
    end else if (w_start) begin
      r_acc    <= '0;
      r_mcand  <= AW'(a_bi);
      r_mplier <= (op_i == OP_MUL) ? b_bi : a_bi;
      r_b      <= b_bi;
    end else if (w_mul_active && !abort_i) begin
      r_acc <= w_acc_next;
      if ((r_state == ST_MUL_A) && w_mul_last) begin
        // Switch to b*b, keeping a*a in the accumulator.
        r_mcand  <= AW'(r_b);
        r_mplier <= r_b;
      end else begin
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign y_bo   = r_y;

endmodule

// File: doc/sr_hyp_unit.md
Name: sr_hyp_unit

Overview:
Parametrised multi-cycle arithmetic coprocessor. It is the successor to the fixed 8-bit math unit attached to the sr_cpu control path.
It computes floor(sqrt(a*a+b*b)), a*b, floor(sqrt(a)) or a*a+b*b from operands latched at start, using a shift-add multiplier and a bit-serial restoring square root.
The start/busy handshake stalls the CPU PC; a one-cycle done pulse and a synchronous abort are new.

Parameters:
WIDTH, 8, operand width in bits (>=2).
OUT_WIDTH, 32, result width; must be >= 2*WIDTH+1 (elaboration-time check).

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
start_i  input  1  request a calculation; sampled only in IDLE.
op_i  input  2  operation: 0=HYP, 1=MUL, 2=SQRT (of a), 3=SQSUM.
a_bi  input  WIDTH  operand a, unsigned.
b_bi  input  WIDTH  operand b, unsigned; ignored for SQRT.
abort_i  input  1  synchronous cancel of a running operation.
busy_o  output  1  high while a calculation is in progress.
done_o  output  1  one-cycle pulse when y_bo takes a new result.
y_bo  output  OUT_WIDTH  result, zero-extended; held until the next completion.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy_o=0, done_o=0, y_bo=0, all datapath registers 0. Reset mid-operation discards the operation with no done_o.
- States: IDLE, MUL_A, MUL_B, SQRT, FIN.
- Start: a clock edge E0 with state IDLE, start_i=1 and abort_i=0 latches a_bi, b_bi and op_i. busy_o rises after E0.
- Operand/op changes while busy are ignored. start_i outside IDLE is ignored; it is not queued.
- Next state after E0:
  - HYP -> MUL_A.
  - MUL -> MUL_A, with multiplier operands (a,b).
  - SQRT -> SQRT, with radicand = a zero-extended.
  - SQSUM -> MUL_A.
- MUL_A: WIDTH cycles, one multiplier bit per cycle, computing a*a (HYP, SQSUM) or a*b (MUL). Product goes to a 2*WIDTH+2-bit accumulator.
  - Exits to FIN for MUL; otherwise to MUL_B.
- MUL_B: WIDTH cycles, computes b*b and adds it into the accumulator.
  - Exits to SQRT for HYP; to FIN for SQSUM.
- SQRT: WIDTH+1 cycles, one root bit per cycle (restoring, MSB first) on the 2*WIDTH+2-bit radicand. The root is WIDTH+1 bits. Exits to FIN.
- FIN:
  - The edge leaving FIN loads y_bo with the result: the root for HYP/SQRT, the accumulator for MUL/SQSUM.
  - The same edge sets done_o=1 for one cycle, drops busy_o and returns to IDLE.
- Busy-cycle count N (edges E0..EN with busy high; y_bo valid and done_o high after EN):
  - HYP: 3*WIDTH+2
  - MUL: WIDTH+1
  - SQRT: WIDTH+2
  - SQSUM: 2*WIDTH+1
  - Deterministic and operand-independent.
- Counter: one shared iteration counter of width clog2(WIDTH+2), cleared on every state entry.
- abort_i=1 in any non-IDLE state: next edge goes to IDLE, busy_o=0, no done_o, y_bo unchanged.
  - abort_i takes priority over FIN completion.
  - abort_i together with start_i in IDLE: no start.
- Back-to-back: start_i high in the cycle done_o is high begins a new operation at that edge (IDLE reached).
- No overflow is possible: the max sum (2^WIDTH-1)^2*2 fits in 2*WIDTH+1 bits.

Decomposition:
- Shared header sr_math.vh: op codes (MATH_OP_HYP/MUL/SQRT/SQSUM) and state encodings. The sr_control decode adds RVF7/RVF3/RVOP_HYP variants that select op_i.
- One natural sub-module: sr_isqrt_serial, the bit-serial restoring square root.
  - Parameter RW (radicand width).
  - Ports: clk, rst_n, load, radicand, step, root, remainder.
  - The multiplier and FSM stay in sr_hyp_unit.

Test Plan:
- WIDTH=8, HYP a=3 b=4 -> busy_o high exactly 26 cycles, then done_o one pulse, y_bo=5; y_bo stays 5 for 10 idle cycles.
- HYP a=255 b=255 -> y_bo=360. MUL a=255 b=255 -> y_bo=65025 after 9 busy cycles. SQSUM a=3 b=4 -> 25 after 17 cycles.
- SQRT a=200 b=77 -> y_bo=14 after 10 busy cycles. SQRT a=0 -> 0. HYP a=0 b=0 -> 0.
- HYP a=3 b=4, then a_bi/b_bi/op_i changed and start_i pulsed at cycle 5 -> still y_bo=5 at cycle 26, exactly one done_o.
- abort_i at busy cycle 12 of HYP a=6 b=8 (previous y_bo=5) -> busy_o low next cycle, no done_o, y_bo=5. Then start HYP a=6 b=8 -> y_bo=10.
- rst_n low at busy cycle 7 of MUL a=12 b=12 -> busy_o, done_o, y_bo immediately 0. After release, start in the first cycle -> y_bo=144. start_i held with done_o -> back-to-back result.
